// File: rtl/bp_update_sched_pkg.sv
// Shared types and constants for the branch predictor update scheduler.
// Entry packing, FSM encodings and the mispredict compare.
package bp_update_sched_pkg;

    localparam int PC_W    = 32;
    localparam int PRED_W  = 2;
    localparam int ENTRY_W = PC_W + PC_W + 1 + 1 + PRED_W + 1;

    localparam logic [1:0] BPU_IDLE    = 2'd0;
    localparam logic [1:0] BPU_RECOVER = 2'd1;
    localparam logic [1:0] BPU_DRAIN   = 2'd2;

    typedef struct packed {
        logic [PC_W-1:0]   pc;
        logic [PC_W-1:0]   target;
        logic              taken;
        logic              is_jump;
        logic [PRED_W-1:0] preds;
        logic              train_meta;
    } bpu_entry_t;

    function automatic logic is_mispred(
        input logic            valid,
        input logic            taken,
        input logic            pred_taken,
        input logic [PC_W-1:0] target,
        input logic [PC_W-1:0] pred_addr
    );
        return valid & ((taken != pred_taken) |
                        (taken & (target != pred_addr)));
    endfunction

endpackage

// File: rtl/bp_update_sched_fifo.sv
// Resolved-branch FIFO: DEPTH entries, extra pointer bit for full/empty.
// Storage is reset so the head reads zero while empty after reset.
module bp_update_fifo
    import bp_update_sched_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int PTR_W = 2
) (
    input  logic               CLK,
    input  logic               RESET,
    input  logic               push,
    input  logic [ENTRY_W-1:0] wdata,
    input  logic               pop,
    output logic [ENTRY_W-1:0] rdata,
    output logic               full,
    output logic               empty
);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W:0]     wptr;
    logic [PTR_W:0]     rptr;

    assign empty = (wptr == rptr);
    assign full  = (wptr[PTR_W] != rptr[PTR_W]) &&
                   (wptr[PTR_W-1:0] == rptr[PTR_W-1:0]);
    assign rdata = mem[rptr[PTR_W-1:0]];

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push && !full) begin
                mem[wptr[PTR_W-1:0]] <= wdata;
                wptr <= wptr + 1'b1;
            end
            if (pop && !empty) rptr <= rptr + 1'b1;
        end
    end

endmodule

// File: rtl/bp_update_sched.sv
// Predictor training scheduler: buffers resolved branches, issues one
// update per cycle, and on a mispredict redirects fetch and flushes.
module bp_update_sched
    import bp_update_sched_pkg::*;
#(
    parameter int DEPTH        = 4,
    parameter int FLUSH_CYCLES = 2,
    parameter int PTR_W        = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        Res_valid,
    input  logic [31:0] Res_pc,
    input  logic [31:0] Res_target,
    input  logic        Res_taken,
    input  logic        Res_is_jump,
    input  logic        Res_is_return,
    input  logic [1:0]  Res_preds,
    input  logic        Res_pred_taken,
    input  logic [31:0] Res_pred_addr,
    output logic        Res_ready,
    output logic        Upd_valid,
    input  logic        Upd_ready,
    output logic [31:0] Upd_pc,
    output logic [31:0] Upd_target,
    output logic        Upd_taken,
    output logic        Upd_train_dir,
    output logic        Upd_train_meta,
    output logic [1:0]  Upd_preds,
    output logic        Ras_repair,
    output logic        Redirect_valid,
    output logic [31:0] Redirect_addr,
    output logic        FLUSH
);

    localparam int CNT_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FLUSH_CYCLES - 1);

    logic [1:0]       state;
    logic [1:0]       state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;
    logic             mispred;
    logic             start_recover;
    bpu_entry_t       wr_entry;
    bpu_entry_t       head;

    assign mispred = is_mispred(Res_valid, Res_taken, Res_pred_taken,
                                Res_target, Res_pred_addr);

    assign Res_ready     = !full && (state != BPU_RECOVER);
    assign push          = Res_valid && Res_ready;
    assign start_recover = push && mispred;
    assign pop           = !empty && Upd_ready;

    always_comb begin
        wr_entry            = '0;
        wr_entry.pc         = Res_pc;
        wr_entry.target     = Res_target;
        wr_entry.taken      = Res_taken;
        wr_entry.is_jump    = Res_is_jump;
        wr_entry.preds      = Res_preds;
        wr_entry.train_meta = !Res_is_jump && (Res_preds[1] != Res_preds[0]);
    end

    bp_update_fifo #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .CLK   (CLK),
        .RESET (RESET),
        .push  (push),
        .wdata (wr_entry),
        .pop   (pop),
        .rdata (head),
        .full  (full),
        .empty (empty)
    );

    assign Upd_valid      = !empty;
    assign Upd_pc         = head.pc;
    assign Upd_target     = head.target;
    assign Upd_taken      = head.taken;
    assign Upd_train_dir  = !head.is_jump;
    assign Upd_train_meta = head.train_meta;
    assign Upd_preds      = head.preds;
    assign FLUSH          = (state == BPU_RECOVER);

    always_comb begin
        state_nxt = state;
        unique case (state)
            BPU_IDLE: begin
                if (start_recover) state_nxt = BPU_RECOVER;
            end
            BPU_RECOVER: begin
                if (cnt == '0) state_nxt = empty ? BPU_IDLE : BPU_DRAIN;
            end
            BPU_DRAIN: begin
                if (start_recover) state_nxt = BPU_RECOVER;
                else if (empty)    state_nxt = BPU_IDLE;
            end
            default: state_nxt = BPU_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state          <= BPU_IDLE;
            cnt            <= '0;
            Redirect_valid <= 1'b0;
            Redirect_addr  <= '0;
            Ras_repair     <= 1'b0;
        end else begin
            state          <= state_nxt;
            Redirect_valid <= start_recover;
            Ras_repair     <= start_recover && Res_is_return;
            if (start_recover) begin
                Redirect_addr <= Res_target;
                cnt           <= CNT_LOAD;
            end else if (state == BPU_RECOVER && cnt != '0) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bp_update_sched.sv
// Directed bench for bp_update_sched with hand-computed expectations.
// Inputs change 1ns after each rising edge; outputs are checked there too.
module tb_bp_update_sched;

    logic        CLK = 1'b0;
    logic        RESET;
    logic        Res_valid;
    logic [31:0] Res_pc;
    logic [31:0] Res_target;
    logic        Res_taken;
    logic        Res_is_jump;
    logic        Res_is_return;
    logic [1:0]  Res_preds;
    logic        Res_pred_taken;
    logic [31:0] Res_pred_addr;
    logic        Res_ready;
    logic        Upd_valid;
    logic        Upd_ready;
    logic [31:0] Upd_pc;
    logic [31:0] Upd_target;
    logic        Upd_taken;
    logic        Upd_train_dir;
    logic        Upd_train_meta;
    logic [1:0]  Upd_preds;
    logic        Ras_repair;
    logic        Redirect_valid;
    logic [31:0] Redirect_addr;
    logic        FLUSH;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK = ~CLK;

    bp_update_sched #(
        .DEPTH        (4),
        .FLUSH_CYCLES (2),
        .PTR_W        (2)
    ) dut (
        .CLK            (CLK),
        .RESET          (RESET),
        .Res_valid      (Res_valid),
        .Res_pc         (Res_pc),
        .Res_target     (Res_target),
        .Res_taken      (Res_taken),
        .Res_is_jump    (Res_is_jump),
        .Res_is_return  (Res_is_return),
        .Res_preds      (Res_preds),
        .Res_pred_taken (Res_pred_taken),
        .Res_pred_addr  (Res_pred_addr),
        .Res_ready      (Res_ready),
        .Upd_valid      (Upd_valid),
        .Upd_ready      (Upd_ready),
        .Upd_pc         (Upd_pc),
        .Upd_target     (Upd_target),
        .Upd_taken      (Upd_taken),
        .Upd_train_dir  (Upd_train_dir),
        .Upd_train_meta (Upd_train_meta),
        .Upd_preds      (Upd_preds),
        .Ras_repair     (Ras_repair),
        .Redirect_valid (Redirect_valid),
        .Redirect_addr  (Redirect_addr),
        .FLUSH          (FLUSH)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    // Drive one resolved instruction (or idle when v=0).
    task automatic res(input logic v, input logic [31:0] pc,
                       input logic [31:0] tgt, input logic tk,
                       input logic jmp, input logic ret,
                       input logic [1:0] pr, input logic ptk,
                       input logic [31:0] pa);
        if (v) chk("proto_res_ready", {31'd0, Res_ready}, 32'd1);
        Res_valid      = v;
        Res_pc         = pc;
        Res_target     = tgt;
        Res_taken      = tk;
        Res_is_jump    = jmp;
        Res_is_return  = ret;
        Res_preds      = pr;
        Res_pred_taken = ptk;
        Res_pred_addr  = pa;
    endtask

    task automatic idle();
        res(1'b0, '0, '0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, '0);
    endtask

    // Correctly predicted not-taken branch at pc.
    task automatic ok_br(input logic [31:0] pc, input logic [1:0] pr);
        res(1'b1, pc, pc + 32'd8, 1'b0, 1'b0, 1'b0, pr, 1'b0, '0);
    endtask

    task automatic do_reset();
        RESET = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b1;
        #1;
    endtask

    logic [31:0] exp_pc;

    initial begin
        Upd_ready = 1'b1;
        idle();
        do_reset();

        chk("rst_res_ready", {31'd0, Res_ready}, 32'd1);
        chk("rst_upd_valid", {31'd0, Upd_valid}, 32'd0);
        chk("rst_flush", {31'd0, FLUSH}, 32'd0);
        chk("rst_redir_v", {31'd0, Redirect_valid}, 32'd0);
        chk("rst_redir_a", Redirect_addr, 32'd0);
        chk("rst_ras", {31'd0, Ras_repair}, 32'd0);
        chk("rst_upd_pc", Upd_pc, 32'd0);

        // Correctly predicted stream of three branches
        cyc();
        ok_br(32'h0040_0000, 2'b10);
        chk("s_vis_nobypass", {31'd0, Upd_valid}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            exp_pc = 32'h0040_0000 + 32'(i * 4);
            chk("s_upd_valid", {31'd0, Upd_valid}, 32'd1);
            chk("s_upd_pc", Upd_pc, exp_pc);
            chk("s_upd_tgt", Upd_target, exp_pc + 32'd8);
            chk("s_train_dir", {31'd0, Upd_train_dir}, 32'd1);
            chk("s_train_meta", {31'd0, Upd_train_meta}, 32'd1);
            chk("s_preds", {30'd0, Upd_preds}, 32'd2);
            chk("s_flush", {31'd0, FLUSH}, 32'd0);
            if (i < 2) ok_br(exp_pc + 32'd4, 2'b10);
            else idle();
        end
        cyc();
        chk("s_drained", {31'd0, Upd_valid}, 32'd0);
        chk("s_flush_end", {31'd0, FLUSH}, 32'd0);

        // Mispredicted taken branch
        res(1'b1, 32'h0040_0020, 32'h0040_0100, 1'b1, 1'b0, 1'b0,
            2'b11, 1'b0, 32'h0);
        cyc();
        idle();
        chk("m_redir_v", {31'd0, Redirect_valid}, 32'd1);
        chk("m_redir_a", Redirect_addr, 32'h0040_0100);
        chk("m_flush1", {31'd0, FLUSH}, 32'd1);
        chk("m_ready1", {31'd0, Res_ready}, 32'd0);
        chk("m_upd_pc", Upd_pc, 32'h0040_0020);
        chk("m_upd_taken", {31'd0, Upd_taken}, 32'd1);
        chk("m_meta", {31'd0, Upd_train_meta}, 32'd0);
        chk("m_ras", {31'd0, Ras_repair}, 32'd0);
        cyc();
        chk("m_redir_pulse", {31'd0, Redirect_valid}, 32'd0);
        chk("m_redir_hold", Redirect_addr, 32'h0040_0100);
        chk("m_flush2", {31'd0, FLUSH}, 32'd1);
        chk("m_ready2", {31'd0, Res_ready}, 32'd0);
        chk("m_popped", {31'd0, Upd_valid}, 32'd0);
        cyc();
        chk("m_flush3", {31'd0, FLUSH}, 32'd0);
        chk("m_ready3", {31'd0, Res_ready}, 32'd1);

        // Backpressure: fill, hold, then release with a push mid-drain
        Upd_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ok_br(32'h0040_1000 + 32'(i * 4), 2'b01);
            cyc();
        end
        idle();
        chk("b_full_ready", {31'd0, Res_ready}, 32'd0);
        chk("b_head0", Upd_pc, 32'h0040_1000);
        repeat (3) cyc();
        chk("b_hold_head", Upd_pc, 32'h0040_1000);
        chk("b_hold_ready", {31'd0, Res_ready}, 32'd0);
        Upd_ready = 1'b1;
        cyc();
        chk("b_head1", Upd_pc, 32'h0040_1004);
        chk("b_ready_after_pop", {31'd0, Res_ready}, 32'd1);
        ok_br(32'h0040_1010, 2'b00);
        cyc();
        idle();
        chk("b_pushpop_head", Upd_pc, 32'h0040_1008);
        chk("b_pushpop_ready", {31'd0, Res_ready}, 32'd1);
        cyc();
        chk("b_head3", Upd_pc, 32'h0040_100c);
        cyc();
        chk("b_head4_wrap", Upd_pc, 32'h0040_1010);
        chk("b_head4_meta", {31'd0, Upd_train_meta}, 32'd0);
        cyc();
        chk("b_empty", {31'd0, Upd_valid}, 32'd0);

        // Mispredicted return
        res(1'b1, 32'h0040_0040, 32'h0040_0200, 1'b1, 1'b1, 1'b1,
            2'b10, 1'b1, 32'h0040_0300);
        cyc();
        idle();
        chk("r_ras", {31'd0, Ras_repair}, 32'd1);
        chk("r_redir_v", {31'd0, Redirect_valid}, 32'd1);
        chk("r_redir_a", Redirect_addr, 32'h0040_0200);
        chk("r_upd_pc", Upd_pc, 32'h0040_0040);
        chk("r_train_dir", {31'd0, Upd_train_dir}, 32'd0);
        chk("r_train_meta", {31'd0, Upd_train_meta}, 32'd0);
        cyc();
        chk("r_ras_pulse", {31'd0, Ras_repair}, 32'd0);
        chk("r_flush2", {31'd0, FLUSH}, 32'd1);
        cyc();
        chk("r_flush_end", {31'd0, FLUSH}, 32'd0);

        // Recovery with a backlog ends in DRAIN, accepting new entries
        Upd_ready = 1'b0;
        res(1'b1, 32'h0040_0060, 32'h0040_0500, 1'b1, 1'b0, 1'b0,
            2'b00, 1'b0, 32'h0);
        cyc();
        idle();
        cyc();
        cyc();
        chk("d_flush_off", {31'd0, FLUSH}, 32'd0);
        chk("d_ready", {31'd0, Res_ready}, 32'd1);
        chk("d_kept", Upd_pc, 32'h0040_0060);

        // Reset asserted during the first flush cycle
        do_reset();
        Upd_ready = 1'b0;
        res(1'b1, 32'h0040_0080, 32'h0040_0600, 1'b1, 1'b0, 1'b0,
            2'b00, 1'b0, 32'h0);
        cyc();
        idle();
        chk("x_flush_pre", {31'd0, FLUSH}, 32'd1);
        RESET = 1'b0;
        #1;
        chk("x_flush_async", {31'd0, FLUSH}, 32'd0);
        chk("x_upd_valid", {31'd0, Upd_valid}, 32'd0);
        chk("x_redir_v", {31'd0, Redirect_valid}, 32'd0);
        @(negedge CLK);
        RESET = 1'b1;
        cyc();
        chk("x_ready", {31'd0, Res_ready}, 32'd1);
        chk("x_empty", {31'd0, Upd_valid}, 32'd0);
        chk("x_flush_post", {31'd0, FLUSH}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
